irq_responder: RTL
==================

Name: irq_responder

Overview:
- Bus-side responder and interrupt controller at the far end of the SM83 core's memory/IRQ interface.
- Holds the IF (0xFF0F) and IE (0xFFFF) registers.
- Answers core RD/WR cycles to those addresses and latches peripheral interrupt requests.
- Drives CPU_IRQ_TRIG to the core and clears IF bits on CPU_IRQ_ACK; raises WAKE for STOP/HALT exit.

Parameters:
- NUM_IRQ, 5, number of implemented interrupt sources (IF/IE bits 0..NUM_IRQ-1).
- IF_ADDR, 16'hFF0F, address of the interrupt flag register.
- IE_ADDR, 16'hFFFF, address of the interrupt enable register.

Ports:
- CLK  in  1  single block clock.
- SYNC_RESET  in  1  synchronous active-high reset, sampled on the rising edge of CLK.
- A  in  16  core address bus.
- D_IN  in  8  core write data (core side of D).
- D_OUT  out  8  read data toward core.
- D_OE  out  1  high while this block drives the data bus.
- RD  in  1  core read strobe, active high.
- WR  in  1  core write strobe, active high.
- MMIO_REQ  in  1  high when A is 0xFExx/0xFFxx; qualifies every access.
- INT_REQ  in  NUM_IRQ  peripheral request levels (bit0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad).
- CPU_IRQ_TRIG  out  8  pending-and-enabled vector to core.
- CPU_IRQ_ACK  in  8  one-hot acknowledge from core during interrupt dispatch.
- WAKE  out  1  high when any IF&IE bit is set.

Behaviour:
- Reset, synchronous, applied on the CLK edge where SYNC_RESET=1:
  - IF=0, IE=0, D_OUT=0, D_OE=0, CPU_IRQ_TRIG=0, WAKE=0.
  - Edge-detect history = current INT_REQ, so a level that is already high raises no request.
  - Reset mid-access aborts it; the access is not re-served after release.
- Request capture:
  - IF[i] sets on the rising edge of INT_REQ[i] (prev=0, now=1), registered.
  - A level held high sets IF once only.
- Write access:
  - Performed on the first cycle of a WR pulse (WR=1, WR_prev=0) with MMIO_REQ=1.
  - Held WR writes once.
  - A==IF_ADDR: IF <= D_IN[NUM_IRQ-1:0]. A==IE_ADDR: IE <= D_IN (all 8 bits stored).
- Read access:
  - RD=1, MMIO_REQ=1 and A matching either address: D_OE=1 from the following cycle until the cycle after RD falls.
  - D_OUT captured on the first RD cycle (latency 1).
  - IF reads as {3'b111, IF[4:0]}; unimplemented bits read 1. IE reads its full 8 bits.
  - Any other address: D_OE=0.
- Acknowledge:
  - CPU_IRQ_ACK[i]=1 clears IF[i] next edge.
  - ACK bits above NUM_IRQ are ignored.
  - Multi-hot ACK clears every indicated bit (not flagged as error).
- Priority for one IF bit in the same cycle: new rising request > ACK clear > CPU write. A set always survives.
- CPU_IRQ_TRIG:
  - Bit i = IF[i]&IE[i], registered; bits 7..NUM_IRQ = 0.
  - Updates one cycle after IF/IE change.
  - Priority resolution is left to the core.
- WAKE = |CPU_IRQ_TRIG, same timing.
- RD and WR both high: the write is performed and the read is ignored (D_OE=0).
- MMIO_REQ=0 masks all access regardless of A.

Decomposition:
- Shared package irq_pkg:
  - Address constants IF_ADDR/IE_ADDR.
  - Source index constants IRQ_VBLANK..IRQ_JOYPAD.
  - Unimplemented-bit read mask 8'hE0.
- One sub-module: irq_edge_detect (NUM_IRQ wide, rising-edge pulse with reset history load).
  - Also reused for the single-bit WR first-cycle detect.

Test Plan:
- Reset with INT_REQ=5'b00001 held high, then release -> IF stays 0x00; reading 0xFF0F returns 0xE0 one cycle after RD.
- IE write 0x05, then INT_REQ[2] pulse -> IF=0x04; CPU_IRQ_TRIG=0x04 and WAKE=1 one cycle later.
- Hold WR high for 4 cycles writing IF=0x1F while INT_REQ[0] rises on cycle 3 -> IF=0x1F once; no rewrite clears the new bit.
- IF=0x01 and CPU_IRQ_ACK=0x01 on the same cycle as an INT_REQ[0] rising edge -> IF[0] remains 1; CPU_IRQ_TRIG[0] stays 1.
- ACK=0x04 with IF=0x05, IE=0xFF -> IF=0x01; CPU_IRQ_TRIG 0x05 -> 0x01.
- Access to 0xFF0F with MMIO_REQ=0, or RD to 0xFF10 -> D_OE=0 and no register change.
- SYNC_RESET asserted during a RD cycle -> D_OE=0 next cycle and IE=0x00.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the SM83 interrupt responder.
// Register addresses, source indices and the IF read mask.
package irq_pkg;

  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  localparam int unsigned IRQ_NUM = 5;

  // IF bits 7..5 do not exist and read back as ones
  localparam logic [7:0] IF_UNIMP_MASK = 8'hE0;

  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } irq_src_e;

  function automatic logic [7:0] if_read_val(
    input logic [7:0] flags
  );
    return IF_UNIMP_MASK | flags;
  endfunction

endpackage

// File: rtl/irq_responder_if.sv
// Core-side memory/IRQ bus as seen by the interrupt responder.
// The core is the master; the responder is the slave.
interface irq_responder_if;

  logic [15:0] A;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        RD;
  logic        WR;
  logic        MMIO_REQ;
  logic [7:0]  CPU_IRQ_TRIG;
  logic [7:0]  CPU_IRQ_ACK;
  logic        WAKE;

  modport master (
    output A,
    output D_IN,
    output RD,
    output WR,
    output MMIO_REQ,
    output CPU_IRQ_ACK,
    input  D_OUT,
    input  D_OE,
    input  CPU_IRQ_TRIG,
    input  WAKE
  );

  modport slave (
    input  A,
    input  D_IN,
    input  RD,
    input  WR,
    input  MMIO_REQ,
    input  CPU_IRQ_ACK,
    output D_OUT,
    output D_OE,
    output CPU_IRQ_TRIG,
    output WAKE
  );

endinterface

// File: rtl/irq_edge_detect.sv
// Rising-edge detector; the history register tracks the level every
// cycle, so a reset leaves an already-high level looking "old".
module irq_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] lvl_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] hist_q;
  logic [W-1:0] hist_d;

  assign hist_d = lvl_i;

  always_ff @(posedge clk_i) begin
    hist_q <= hist_d;
  end

  assign rise_o = rst_i ? '0 : (lvl_i & ~hist_q);

endmodule

// File: rtl/irq_responder.sv
// IF/IE register block and interrupt trigger for the SM83 core.
// Serves core reads/writes and latches peripheral request edges.
module irq_responder #(
  parameter int          NUM_IRQ = 5,
  parameter logic [15:0] IF_ADDR = irq_pkg::IF_ADDR,
  parameter logic [15:0] IE_ADDR = irq_pkg::IE_ADDR
) (
  input  logic               CLK,
  input  logic               SYNC_RESET,
  input  logic [NUM_IRQ-1:0] INT_REQ,
  irq_responder_if.slave     bus
);

  import irq_pkg::*;

  logic [NUM_IRQ-1:0] irq_rise;
  logic               wr_rise;
  logic               rd_rise;

  logic               hit_if;
  logic               hit_ie;
  logic               wr_go;
  logic               rd_ok;
  logic               rd_go;
  logic [NUM_IRQ-1:0] ack;

  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] if_d;
  logic [7:0]         ie_q;
  logic [7:0]         ie_d;
  logic [7:0]         dout_q;
  logic [7:0]         dout_d;
  logic               doe_q;
  logic               doe_d;
  logic [7:0]         trig_q;
  logic [7:0]         trig_d;
  logic               wake_q;
  logic               wake_d;

  irq_edge_detect #(
    .W (NUM_IRQ)
  ) u_irq_edge (
    .clk_i  (CLK),
    .rst_i  (SYNC_RESET),
    .lvl_i  (INT_REQ),
    .rise_o (irq_rise)
  );

  irq_edge_detect #(
    .W (1)
  ) u_wr_edge (
    .clk_i  (CLK),
    .rst_i  (SYNC_RESET),
    .lvl_i  (bus.WR),
    .rise_o (wr_rise)
  );

  irq_edge_detect #(
    .W (1)
  ) u_rd_edge (
    .clk_i  (CLK),
    .rst_i  (SYNC_RESET),
    .lvl_i  (bus.RD),
    .rise_o (rd_rise)
  );

  assign hit_if = (bus.A == IF_ADDR);
  assign hit_ie = (bus.A == IE_ADDR);

  assign wr_go = wr_rise & bus.MMIO_REQ;

  // a concurrent write wins, so the read side stays off the bus
  assign rd_ok = bus.RD & ~bus.WR & bus.MMIO_REQ
               & (hit_if | hit_ie);
  assign rd_go = rd_ok & rd_rise;

  assign ack = bus.CPU_IRQ_ACK[NUM_IRQ-1:0];

  generate
    if (NUM_IRQ < 8) begin : g_ack_hi
      logic unused_ack_hi;
      assign unused_ack_hi = ^bus.CPU_IRQ_ACK[7:NUM_IRQ];
    end
  endgenerate

  always_comb begin
    if_d = if_q;
    if (wr_go && hit_if) begin
      if_d = bus.D_IN[NUM_IRQ-1:0];
    end
    // new request beats ack, ack beats the CPU write
    if_d = (if_d & ~ack) | irq_rise;
  end

  always_comb begin
    ie_d = ie_q;
    if (wr_go && hit_ie) begin
      ie_d = bus.D_IN;
    end
  end

  always_comb begin
    doe_d  = rd_go | (doe_q & rd_ok);
    dout_d = dout_q;
    if (rd_go) begin
      dout_d = hit_if ? if_read_val(8'(if_q)) : ie_q;
    end
  end

  always_comb begin
    trig_d = '0;
    trig_d[NUM_IRQ-1:0] = if_q & ie_q[NUM_IRQ-1:0];
    wake_d = |trig_d;
  end

  always_ff @(posedge CLK) begin
    if (SYNC_RESET) begin
      if_q   <= '0;
      ie_q   <= '0;
      dout_q <= '0;
      doe_q  <= 1'b0;
      trig_q <= '0;
      wake_q <= 1'b0;
    end else begin
      if_q   <= if_d;
      ie_q   <= ie_d;
      dout_q <= dout_d;
      doe_q  <= doe_d;
      trig_q <= trig_d;
      wake_q <= wake_d;
    end
  end

  assign bus.D_OUT        = dout_q;
  assign bus.D_OE         = doe_q;
  assign bus.CPU_IRQ_TRIG = trig_q;
  assign bus.WAKE         = wake_q;

endmodule
